// File: rtl/fb_pkg.sv
// Shared constants, types and address helper for the frame buffer renderer.
//   - Frame geometry (160x120 stored pixels, 4x4 screen blocks)
//   - Screen geometry (640x480) and the off-screen coordinate marker
//   - FSM state type and the y*160+x address function
package fb_pkg;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int SHIFT    = 2;
    localparam int FB_DEPTH = FB_W * FB_H;  // 19200
    localparam int SCR_W    = 640;
    localparam int SCR_H    = 480;
    localparam int ADDR_W   = 15;

    localparam logic [9:0] NO_COORD = 10'h3FF;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // y*160 + x built from shifts: (y<<7) + (y<<5) + x, 15 bits wide.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] x, input logic [6:0] y);
        logic [ADDR_W-1:0] yw;
        yw = {8'b0, y};
        return (yw << 7) + (yw << 5) + {7'b0, x};
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port 19200x6 frame RAM, block-RAM inferable.
//   clk      : clock
//   we       : write enable
//   wr_addr  : write address (15 bits)
//   wr_data  : write colour {R,G,B}
//   rd_addr  : read address (15 bits)
//   rd_data  : registered read colour; a same-cycle write to the same
//              address returns the old contents (read-first)
module fb_ram
    import fb_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [14:0] wr_addr,
    input  logic [5:0]  wr_data,
    input  logic [14:0] rd_addr,
    output logic [5:0]  rd_data
);

    // NOTE: the array has no reset; block RAM cannot be reset, and the
    // clear engine in the top module initialises the contents instead.
    logic [5:0] mem [FB_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/frame_buffer_renderer.sv
// Frame buffer pixel source for the VGA timing stage.
//   CLOCK_50     : sole clock
//   reset        : synchronous active-low reset
//   pix_x, pix_y : current screen coordinate (10'h3FF when off-screen)
//   R, G, B      : 2-bit colour, two cycles after the coordinate
//   wr_valid/wr_ready, wr_x, wr_y, wr_color : pixel write port
//   clear_req, clear_color : start a full-frame fill (ignored while busy)
//   busy         : high while the clear engine runs
module frame_buffer_renderer
    import fb_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic [5:0] wr_color,
    input  logic       clear_req,
    input  logic [5:0] clear_color,
    output logic       busy
);

    state_t      state;
    logic [14:0] clr_addr;
    logic [5:0]  clr_color;

    // ------------------------------------------------------------------
    // Control FSM: clear engine and write-port readiness.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register sees the values from before the clock edge.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            clr_color <= '0;
            busy      <= 1'b1;
            wr_ready  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_addr == 15'(FB_DEPTH - 1)) begin
                        state    <= RUN;
                        clr_addr <= '0;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 15'd1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        state     <= CLEAR;
                        clr_addr  <= '0;
                        clr_color <= clear_color;
                        busy      <= 1'b1;
                        wr_ready  <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM write mux: clear engine owns the port in CLEAR, the write
    // handshake owns it in RUN. Out-of-frame writes are accepted but
    // never reach the RAM.
    // ------------------------------------------------------------------
    logic        wr_fire;
    logic        wr_in_range;
    logic        ram_we;
    logic [14:0] ram_waddr;
    logic [5:0]  ram_wdata;

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

    // NOTE: defaults are assigned first so every path drives every signal
    // and no latch is inferred.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr;
        ram_wdata = clr_color;
        if (reset) begin
            if (state == CLEAR) begin
                ram_we = 1'b1;
            end else if (wr_fire && wr_in_range) begin
                ram_we    = 1'b1;
                ram_waddr = fb_addr(wr_x, wr_y);
                ram_wdata = wr_color;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. Stage 1 registers the address and the on-screen
    // flag; stage 2 is the RAM's data register, gated by the flag that
    // travelled alongside it so blanking never shows stale colour.
    // ------------------------------------------------------------------
    logic        coord_ok;
    logic [7:0]  fx;
    logic [6:0]  fy;
    logic [14:0] rd_addr;
    logic        rd_valid1;
    logic        rd_valid2;
    logic [5:0]  rd_data;

    assign coord_ok = (pix_x < 10'(SCR_W)) && (pix_y < 10'(SCR_H));
    assign fx       = pix_x[SHIFT +: 8];
    assign fy       = pix_y[SHIFT +: 7];

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            rd_addr   <= '0;
            rd_valid1 <= 1'b0;
            rd_valid2 <= 1'b0;
        end else begin
            // Off-screen coordinates park the address at 0 so the RAM is
            // never indexed beyond its depth.
            rd_addr   <= coord_ok ? fb_addr(fx, fy) : '0;
            rd_valid1 <= coord_ok;
            rd_valid2 <= rd_valid1;
        end
    end

    fb_ram u_ram (
        .clk     (CLOCK_50),
        .we      (ram_we),
        .wr_addr (ram_waddr),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign {R, G, B} = rd_valid2 ? rd_data : 6'b0;

endmodule

// File: tb/tb_frame_buffer_renderer.sv
// Directed testbench for frame_buffer_renderer.
module tb_frame_buffer_renderer;

    logic       CLOCK_50;
    logic       reset;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [1:0] R;
    logic [1:0] G;
    logic [1:0] B;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_x;
    logic [6:0] wr_y;
    logic [5:0] wr_color;
    logic       clear_req;
    logic [5:0] clear_color;
    logic       busy;

    int errors = 0;
    int checks = 0;

    localparam int DEPTH    = 19200;
    localparam int BUSY_MAX = 25000;

    frame_buffer_renderer dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .R           (R),
        .G           (G),
        .B           (B),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .busy        (busy)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Present a coordinate at a negedge and return the colour two cycles later.
    task automatic read_pix(input logic [9:0] x, input logic [9:0] y, output logic [5:0] rgb);
        pix_x = x;
        pix_y = y;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        rgb = {R, G, B};
    endtask

    // One-cycle write; returns wr_ready as seen during the transfer cycle.
    task automatic write_px(input logic [7:0] x, input logic [6:0] y, input logic [5:0] c,
                            output logic acc);
        wr_x     = x;
        wr_y     = y;
        wr_color = c;
        wr_valid = 1'b1;
        acc      = wr_ready;
        @(negedge CLOCK_50);
        wr_valid = 1'b0;
    endtask

    // Number of consecutive negedge samples with busy high, from now on.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < BUSY_MAX) begin
            n++;
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset();
        int n;
        reset       = 1'b0;
        pix_x       = 10'd0;
        pix_y       = 10'd0;
        wr_valid    = 1'b0;
        wr_x        = '0;
        wr_y        = '0;
        wr_color    = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr_ready: got %b expected 0", wr_ready);
        end
        checks++;
        if ({R, G, B} !== 6'b0) begin
            errors++;
            $display("FAIL reset_rgb: got %b expected 000000", {R, G, B});
        end
        reset = 1'b1;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_clear_len: busy cycles %0d expected %0d", n, DEPTH);
        end
    endtask

    // Starts on the first RUN cycle after the power-up clear.
    task automatic test_write_read();
        logic       acc;
        logic [5:0] rgb;
        write_px(8'd10, 7'd5, 6'b110000, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL first_run_write: wr_ready %b expected 1", acc);
        end
        write_px(8'd0, 7'd6, 6'b001100, acc);
        for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
                read_pix(10'(40 + dx), 10'(20 + dy), rgb);
                checks++;
                if (rgb !== 6'b110000) begin
                    errors++;
                    $display("FAIL red_block (%0d,%0d): got %b expected 110000", 40 + dx, 20 + dy, rgb);
                end
            end
        end
        read_pix(10'd44, 10'd20, rgb);
        checks++;
        if (rgb !== 6'b0) begin
            errors++;
            $display("FAIL right_neighbour: got %b expected 000000", rgb);
        end
        read_pix(10'd39, 10'd23, rgb);
        checks++;
        if (rgb !== 6'b0) begin
            errors++;
            $display("FAIL left_neighbour: got %b expected 000000", rgb);
        end
        read_pix(10'd40, 10'd24, rgb);
        checks++;
        if (rgb !== 6'b0) begin
            errors++;
            $display("FAIL below_neighbour: got %b expected 000000", rgb);
        end
        read_pix(10'd2, 10'd25, rgb);
        checks++;
        if (rgb !== 6'b001100) begin
            errors++;
            $display("FAIL green_pixel: got %b expected 001100", rgb);
        end
        read_pix(10'd639, 10'd479, rgb);
        checks++;
        if (rgb !== 6'b0) begin
            errors++;
            $display("FAIL corner_black: got %b expected 000000", rgb);
        end
    endtask

    // Read and write of the same address in one cycle returns old data.
    task automatic test_collision();
        logic [5:0] rgb;
        pix_x = 10'd12;
        pix_y = 10'd12;
        @(negedge CLOCK_50);
        wr_x     = 8'd3;
        wr_y     = 7'd3;
        wr_color = 6'b111111;
        wr_valid = 1'b1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL collision_ready: got %b expected 1", wr_ready);
        end
        @(negedge CLOCK_50);
        wr_valid = 1'b0;
        rgb = {R, G, B};
        checks++;
        if (rgb !== 6'b0) begin
            errors++;
            $display("FAIL collision_old_data: got %b expected 000000", rgb);
        end
        @(negedge CLOCK_50);
        rgb = {R, G, B};
        checks++;
        if (rgb !== 6'b111111) begin
            errors++;
            $display("FAIL collision_new_data: got %b expected 111111", rgb);
        end
    endtask

    task automatic test_blanking();
        logic [9:0] xs [6] = '{10'h3FF, 10'd40,   10'd640, 10'h3FF, 10'd0,   10'h3FF};
        logic [9:0] ys [6] = '{10'd20,  10'h3FF,  10'd20,  10'd100, 10'd480, 10'h3FF};
        logic [5:0] rgb;
        for (int i = 0; i < 6; i++) begin
            // Park on a lit pixel first so a leak would be visible.
            read_pix(10'd40, 10'd20, rgb);
            read_pix(xs[i], ys[i], rgb);
            checks++;
            if (rgb !== 6'b0) begin
                errors++;
                $display("FAIL blank_%0d (%0d,%0d): got %b expected 000000", i, xs[i], ys[i], rgb);
            end
        end
    endtask

    task automatic test_clear();
        int         n;
        int         shown;
        int         fx;
        int         fy;
        logic       acc;
        @(negedge CLOCK_50);
        clear_color = 6'b000011;
        clear_req   = 1'b1;
        checks++;
        if (wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pre_clear: wr_ready %b busy %b expected 1 0", wr_ready, busy);
        end
        @(negedge CLOCK_50);
        clear_req   = 1'b0;
        clear_color = 6'b000000;
        checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_start: wr_ready %b busy %b expected 0 1", wr_ready, busy);
        end
        n = 0;
        while (busy === 1'b1 && n < BUSY_MAX) begin
            n++;
            if (n == 5000) begin
                clear_req   = 1'b1;
                clear_color = 6'b110000;
            end else begin
                clear_req = 1'b0;
            end
            @(negedge CLOCK_50);
        end
        clear_req = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_len: busy cycles %0d expected %0d", n, DEPTH);
        end
        // Out-of-frame writes: accepted, data discarded.
        write_px(8'd200, 7'd5, 6'b110000, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL oor_x_ready: got %b expected 1", acc);
        end
        write_px(8'd0, 7'd120, 6'b110000, acc);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL oor_y_ready: got %b expected 1", acc);
        end
        // Pipelined full-frame readback, one coordinate per cycle.
        shown = 0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (k >= 2) begin
                checks++;
                if ({R, G, B} !== 6'b000011) begin
                    errors++;
                    if (shown < 8) begin
                        $display("FAIL frame_blue idx %0d: got %b expected 000011", k - 2, {R, G, B});
                    end
                    shown++;
                end
            end
            if (k < DEPTH) begin
                fy    = k / 160;
                fx    = k % 160;
                pix_x = 10'(fx * 4 + (fy % 4));
                pix_y = 10'(fy * 4 + (fx % 4));
            end
            @(negedge CLOCK_50);
        end
    endtask

    task automatic test_reset_mid_clear();
        int         n;
        logic [5:0] rgb;
        logic [9:0] xs [4] = '{10'd0, 10'd160, 10'd320, 10'd639};
        logic [9:0] ys [4] = '{10'd0, 10'd124, 10'd448, 10'd479};
        clear_color = 6'b001100;
        clear_req   = 1'b1;
        @(negedge CLOCK_50);
        clear_req = 1'b0;
        pix_x     = 10'd0;
        pix_y     = 10'd0;
        repeat (9000) @(negedge CLOCK_50);
        checks++;
        if ({R, G, B} !== 6'b001100) begin
            errors++;
            $display("FAIL mid_clear_green: got %b expected 001100", {R, G, B});
        end
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (busy !== 1'b1 || wr_ready !== 1'b0 || {R, G, B} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy %b wr_ready %b rgb %b expected 1 0 000000",
                     busy, wr_ready, {R, G, B});
        end
        reset = 1'b1;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL restart_clear_len: busy cycles %0d expected %0d", n, DEPTH);
        end
        for (int i = 0; i < 4; i++) begin
            read_pix(xs[i], ys[i], rgb);
            checks++;
            if (rgb !== 6'b0) begin
                errors++;
                $display("FAIL restart_black_%0d: got %b expected 000000", i, rgb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_blanking();
        test_clear();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
